unidade_load_store: RTL
=======================

# unidade_load_store

Initiator-side controller for the word-addressed data memory port: accepts byte/halfword/word load and store requests from the CPU datapath and turns them into memory accesses (endereco, memWrite, dado_Escrito, dado_Lido). Sub-word stores use read-modify-write, because the memory only writes full words. The block sits between the EX/MEM stage and the data memory, and owns every memory access.

## Interface
Parameters:
- ADDR_W, 26: word-address width driven on `endereco`; CPU byte address is ADDR_W+2 bits.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- req  in  1  request strobe; sampled only while `pronto`=1.
- op  in  3  000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU, 101 SB, 110 SH, 111 SW.
- addr  in  ADDR_W+2  byte address.
- wdata  in  32  store data; byte/half taken from low bits.
- pronto  out  1  idle, can accept `req`.
- concluido  out  1  one-cycle completion pulse.
- erro  out  1  misaligned access; valid with `concluido`.
- rdata  out  32  load result; held until next load completes.
- endereco  out  ADDR_W  word address to memory (addr[ADDR_W+1:2]).
- memWrite  out  1  memory write enable.
- dado_Escrito  out  32  word to memory.
- dado_Lido  in  32  memory read data, combinational from `endereco`.

## Operation
- FSM states: OCIOSO, LER, ESCREVER, FIM.
- OCIOSO: `pronto`=1. On `req`, latch op, addr and wdata.
  - If misaligned (see Configuration): go to FIM with the error flag set; no memory access.
  - SW goes to ESCREVER. All other ops go to LER.
- LER: drive `endereco` from the latched address and capture `dado_Lido` into the buffer at the edge.
  - Loads: extract the lanes, extend, then go to FIM.
  - SB/SH: merge the new bytes into the buffer, then go to ESCREVER.
- ESCREVER: `memWrite`=1 and `dado_Escrito`=merged word (SW: wdata), then go to FIM.
- FIM: `concluido`=1, `erro` valid, then return to OCIOSO.
- Byte lanes are little-endian: offset 0 maps to bits 7:0 and offset 3 to bits 31:24. A halfword at offset 2 maps to bits 31:16.
- LB and LH sign-extend. LBU and LHU zero-extend.
- `rdata` updates only on a load completing without error. Stores and errors leave it unchanged.
- `req` while `pronto`=0 is ignored; there is no queueing.
- `endereco` holds the last latched word address in every state. `dado_Escrito` is 0 outside ESCREVER.

## Timing
- Cycle 0 is the cycle `req` is accepted. `concluido` asserts in:
  - cycle 2 for loads and SW;
  - cycle 3 for SB/SH;
  - cycle 1 for misaligned accesses.
- `pronto` is asserted in the cycle after `concluido`. The minimum request spacing for back-to-back loads is therefore 3 cycles.
- `memWrite` asserts for exactly one cycle per store.
- Reset values: state OCIOSO, `pronto`=1, `concluido`=0, `erro`=0, `rdata`=0, `endereco`=0, `memWrite`=0, `dado_Escrito`=0.
- `memWrite` is gated with `!reset`, so reset in ESCREVER suppresses the write at that edge.
- Reset in any state aborts the access: no `concluido` pulse, and the block is idle the next cycle.
- `req` asserted together with `reset` is dropped.

## Configuration
- LSU_ALIGN_CHECK_EN defined:
  - LH/LHU/SH with addr[0]=1 is misaligned.
  - LW/SW with addr[1:0]≠0 is misaligned.
  - A misaligned access raises `erro` with `concluido` at cycle 1 and never touches memory.
- Undefined:
  - `erro` is tied 0.
  - Halfword ops ignore addr[0] and word ops ignore addr[1:0].

## Structure
- Package `pacote_lsu` holds the op-code constants (OP_LB … OP_SW), the FSM state enum, and the helper predicates `eh_store` and `eh_unsigned`.
- Sub-module `alinhador_bytes` (combinational) provides:
  - load extract/extend: word, offset, size, signedness → 32-bit result;
  - store merge: old word, new data, offset, size → merged word.

## Test plan
- LW at addr 0x10, memory word 4 = 0xDEADBEEF → `endereco`=4, `concluido` in cycle 2, `rdata`=0xDEADBEEF.
- LB at 0x13 on 0x80FF0102 → `rdata`=0xFFFFFF80. LBU at the same address → `rdata`=0x00000080.
- SB 0x5A at 0x21 onto 0x11223344 → one `memWrite` pulse in cycle 2 with `dado_Escrito`=0x11225A44, `concluido` in cycle 3. A following LW returns 0x11225A44.
- With LSU_ALIGN_CHECK_EN, LW at 0x22 → `concluido` and `erro` in cycle 1, `memWrite` never high, `rdata` unchanged.
- SH 0xBEEF at 0x0E, reset asserted in the ESCREVER cycle → no write (memory unchanged), no `concluido`, `pronto`=1 the next cycle.
- `req` pulsed during LER of a prior LW → ignored; exactly one `concluido`.

Source files
------------

// File: rtl/unidade_load_store_pkg.sv
// Shared definitions for the load/store unit: op codes, FSM states and op decoding helpers.
// The optional alignment check is enabled by defining LSU_ALIGN_CHECK_EN.
package pacote_lsu;

  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LW  = 3'b010;
  localparam logic [2:0] OP_LBU = 3'b011;
  localparam logic [2:0] OP_LHU = 3'b100;
  localparam logic [2:0] OP_SB  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SW  = 3'b111;

  typedef enum logic [1:0] {OCIOSO, LER, ESCREVER, FIM} estado_t;
  typedef enum logic [1:0] {TAM_BYTE, TAM_MEIA, TAM_PALAVRA} tamanho_t;

  function automatic logic eh_store(input logic [2:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic eh_unsigned(input logic [2:0] op);
    return (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic tamanho_t tamanho(input logic [2:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return TAM_BYTE;
      OP_LH, OP_LHU, OP_SH: return TAM_MEIA;
      default:              return TAM_PALAVRA;
    endcase
  endfunction

endpackage

// File: rtl/unidade_load_store_alinhador_bytes.sv
// Combinational byte-lane logic: load extract/extend and sub-word store merge (little-endian).
module alinhador_bytes
  import pacote_lsu::*;
(
  input  logic [31:0] palavra_i,
  input  logic [1:0]  offset_i,
  input  tamanho_t    tamanho_i,
  input  logic        sem_sinal_i,
  input  logic [31:0] novo_i,
  output logic [31:0] carga_o,
  output logic [31:0] mesclado_o
);

  logic [7:0]  byte_sel;
  logic [15:0] meia_sel;

  always_comb begin
    byte_sel   = palavra_i[{offset_i, 3'b000} +: 8];
    meia_sel   = palavra_i[{offset_i[1], 4'b0000} +: 16];
    carga_o    = palavra_i;
    mesclado_o = novo_i;
    case (tamanho_i)
      TAM_BYTE: begin
        carga_o    = {{24{!sem_sinal_i && byte_sel[7]}}, byte_sel};
        mesclado_o = palavra_i;
        mesclado_o[{offset_i, 3'b000} +: 8] = novo_i[7:0];
      end
      TAM_MEIA: begin
        carga_o    = {{16{!sem_sinal_i && meia_sel[15]}}, meia_sel};
        mesclado_o = palavra_i;
        mesclado_o[{offset_i[1], 4'b0000} +: 16] = novo_i[15:0];
      end
      default: begin
        carga_o    = palavra_i;
        mesclado_o = novo_i;
      end
    endcase
  end

endmodule

// File: rtl/unidade_load_store.sv
// Load/store unit owning the word-addressed data memory port; sub-word stores use read-modify-write.
// Define LSU_ALIGN_CHECK_EN to flag misaligned halfword/word accesses through erro.
module unidade_load_store
  import pacote_lsu::*;
#(
  parameter int ADDR_W = 26
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic [2:0]        op,
  input  logic [ADDR_W+1:0] addr,
  input  logic [31:0]       wdata,
  output logic              pronto,
  output logic              concluido,
  output logic              erro,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] endereco,
  output logic              memWrite,
  output logic [31:0]       dado_Escrito,
  input  logic [31:0]       dado_Lido,
  output estado_t           estado_o
);

  estado_t           estado_q;
  logic [2:0]        op_q;
  logic [1:0]        off_q;
  logic [31:0]       dado_q;
  logic [31:0]       rdata_q;
  logic [ADDR_W-1:0] endereco_q;

  tamanho_t    tam_req;
  logic [1:0]  off_ef;
  logic        desalinhado;
  logic [31:0] carga;
  logic [31:0] mesclado;

  assign tam_req = tamanho(op);

  // Halfwords and words ignore the low address bits when they are not being checked.
  always_comb begin
    case (tam_req)
      TAM_BYTE: off_ef = addr[1:0];
      TAM_MEIA: off_ef = {addr[1], 1'b0};
      default:  off_ef = 2'b00;
    endcase
  end

`ifdef LSU_ALIGN_CHECK_EN
  logic erro_q;
  assign desalinhado = ((tam_req == TAM_MEIA) && addr[0]) ||
                       ((tam_req == TAM_PALAVRA) && (addr[1:0] != 2'b00));
  assign erro = (estado_q == FIM) && erro_q;
`else
  assign desalinhado = 1'b0;
  assign erro        = 1'b0;
`endif

  alinhador_bytes u_alinhador (
    .palavra_i   (dado_Lido),
    .offset_i    (off_q),
    .tamanho_i   (tamanho(op_q)),
    .sem_sinal_i (eh_unsigned(op_q)),
    .novo_i      (dado_q),
    .carga_o     (carga),
    .mesclado_o  (mesclado)
  );

  // dado_q holds the store data at accept and the merged word after LER.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q   <= OCIOSO;
      op_q       <= OP_LB;
      off_q      <= 2'b00;
      dado_q     <= '0;
      rdata_q    <= '0;
      endereco_q <= '0;
`ifdef LSU_ALIGN_CHECK_EN
      erro_q     <= 1'b0;
`endif
    end else begin
      case (estado_q)
        OCIOSO: begin
          if (req) begin
            op_q       <= op;
            off_q      <= off_ef;
            dado_q     <= wdata;
            endereco_q <= addr[ADDR_W+1:2];
`ifdef LSU_ALIGN_CHECK_EN
            erro_q     <= desalinhado;
`endif
            if (desalinhado)       estado_q <= FIM;
            else if (op == OP_SW)  estado_q <= ESCREVER;
            else                   estado_q <= LER;
          end
        end
        LER: begin
          if (eh_store(op_q)) begin
            dado_q   <= mesclado;
            estado_q <= ESCREVER;
          end else begin
            rdata_q  <= carga;
            estado_q <= FIM;
          end
        end
        ESCREVER: estado_q <= FIM;
        default:  estado_q <= OCIOSO;
      endcase
    end
  end

  assign pronto       = (estado_q == OCIOSO);
  assign concluido    = (estado_q == FIM);
  assign rdata        = rdata_q;
  assign endereco     = endereco_q;
  assign memWrite     = (estado_q == ESCREVER) && !reset;
  assign dado_Escrito = (estado_q == ESCREVER) ? dado_q : 32'h0;
  assign estado_o     = estado_q;

endmodule
